fifo_cell_ctrl: RTL and testbench

FIFO_CELL_CTRL -- requirements
Module: fifo_cell_ctrl

---
 rtl/fifo_cell_ctrl.sv | 51 +++++
 tb/tb_fifo_cell_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fifo_cell_ctrl.sv
// fifo_cell_ctrl: token-ring controller steering writes into and reads out of DEPTH register cells in FIFO order.
module fifo_cell_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_put,
    input  logic                   req_get,
    output logic [DEPTH-1:0]       put_en,
    output logic [DEPTH-1:0]       get_sel,
    output logic                   get_ack,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   put_err,
    output logic                   get_err
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [DEPTH-1:0] put_tok, get_tok;
    logic             put_acc, get_acc;
    logic [CW-1:0]    count_nxt;
    // Gating with reset keeps cells untouched while the controller is being cleared.
    always_comb begin
        put_acc   = req_put & ~full & ~reset;
        get_acc   = req_get & ~empty & ~reset;
        put_en    = put_acc ? put_tok : '0;
        get_sel   = get_tok;
        get_ack   = get_acc;
        count_nxt = (put_acc & ~get_acc) ? count + CW'(1) :
                    (get_acc & ~put_acc) ? count - CW'(1) : count;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            put_tok <= DEPTH'(1);
            get_tok <= DEPTH'(1);
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            put_err <= 1'b0;
            get_err <= 1'b0;
        end else begin
            if (put_acc) put_tok <= {put_tok[DEPTH-2:0], put_tok[DEPTH-1]};
            if (get_acc) get_tok <= {get_tok[DEPTH-2:0], get_tok[DEPTH-1]};
            count   <= count_nxt;
            full    <= count_nxt == CW'(DEPTH);
            empty   <= count_nxt == '0;
            put_err <= req_put & full;
            get_err <= req_get & empty;
        end
    end
endmodule

// File: tb/tb_fifo_cell_ctrl.sv
// tb_fifo_cell_ctrl: directed self-checking bench for fifo_cell_ctrl at DEPTH=4 with a model cell array.
module tb_fifo_cell_ctrl;
    localparam int DEPTH = 4;
    logic       clk = 1'b0;
    logic       reset, req_put, req_get;
    logic [3:0] put_en, get_sel;
    logic       get_ack, full, empty, put_err, get_err;
    logic [2:0] count;
    logic [7:0] wdata, rdata;
    logic [7:0] cells [DEPTH];
    int         checks = 0;
    int         errors = 0;

    fifo_cell_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req_put(req_put), .req_get(req_get),
        .put_en(put_en), .get_sel(get_sel), .get_ack(get_ack), .full(full),
        .empty(empty), .count(count), .put_err(put_err), .get_err(get_err)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk)
        for (int i = 0; i < DEPTH; i++)
            if (put_en[i]) cells[i] <= wdata;

    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++)
            if (get_sel[i]) rdata = rdata | cells[i];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic p, input logic g, input logic [7:0] d);
        reset = r; req_put = p; req_get = g; wdata = d;
        #1;
    endtask

    initial begin
        drive(1, 1, 1, 8'h00);
        check("rst_put_en", put_en, 0);
        check("rst_get_ack", get_ack, 0);
        cyc();
        drive(0, 0, 0, 8'h00);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_put_err", put_err, 0);
        check("rst_get_err", get_err, 0);
        check("rst_get_sel", get_sel, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 8'hA0 + 8'(i));
            check("fill_put_en", put_en, 4'b0001 << i);
            cyc();
            check("fill_count", count, i + 1);
            check("fill_full", full, i == 3);
            check("fill_empty", empty, 0);
        end
        drive(0, 1, 0, 8'hEE);
        check("ovf_put_en", put_en, 0);
        cyc();
        drive(0, 0, 0, 8'h00);
        check("ovf_put_err", put_err, 1);
        check("ovf_count", count, 4);
        cyc();
        check("ovf_put_err_clr", put_err, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 8'h00);
            check("drain_get_sel", get_sel, 4'b0001 << i);
            check("drain_get_ack", get_ack, 1);
            check("drain_data", rdata, 8'hA0 + 8'(i));
            cyc();
            check("drain_count", count, 3 - i);
        end
        check("drain_empty", empty, 1);
        check("drain_full", full, 0);
        check("udf_get_ack", get_ack, 0);
        cyc();
        check("udf_get_err", get_err, 1);
        check("udf_count", count, 0);
        drive(0, 1, 1, 8'hB0);
        check("emp_both_put_en", put_en, 4'b0001);
        check("emp_both_get_ack", get_ack, 0);
        cyc();
        check("emp_both_count", count, 1);
        check("emp_both_get_err", get_err, 1);
        check("emp_both_empty", empty, 0);
        drive(0, 1, 0, 8'hB1);
        check("two_put_en", put_en, 4'b0010);
        cyc();
        check("two_count", count, 2);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 1, 8'hC0 + 8'(i));
            check("pg_put_en", put_en, 4'b0001 << ((2 + i) % 4));
            check("pg_get_sel", get_sel, 4'b0001 << (i % 4));
            check("pg_get_ack", get_ack, 1);
            check("pg_data", rdata, i == 0 ? 8'hB0 : i == 1 ? 8'hB1 : 8'hC0 + 8'(i - 2));
            cyc();
            check("pg_count", count, 2);
        end
        check("pg_get_tok", get_sel, 4'b0100);
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 8'hD0 + 8'(i));
            check("refill_put_en", put_en, 4'b0001 << i);
            cyc();
            check("refill_count", count, 3 + i);
        end
        check("refill_full", full, 1);
        drive(0, 1, 1, 8'hEE);
        check("full_both_put_en", put_en, 0);
        check("full_both_get_ack", get_ack, 1);
        check("full_both_get_sel", get_sel, 4'b0100);
        check("full_both_data", rdata, 8'hC4);
        cyc();
        check("full_both_count", count, 3);
        check("full_both_put_err", put_err, 1);
        check("full_both_full", full, 0);
        drive(1, 1, 1, 8'hEE);
        check("mid_rst_put_en", put_en, 0);
        check("mid_rst_get_ack", get_ack, 0);
        cyc();
        drive(0, 1, 0, 8'hF0);
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_full", full, 0);
        check("mid_rst_put_err", put_err, 0);
        check("mid_rst_get_sel", get_sel, 4'b0001);
        check("mid_rst_put_en", put_en, 4'b0001);
        cyc();
        drive(0, 0, 0, 8'h00);
        check("post_rst_count", count, 1);
        check("post_rst_data", rdata, 8'hF0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
